// File: rtl/dma_break_arb.sv
// rtl/dma_break_arb.sv - data-break (DB0/DB1/DB2) sequencer and two-port DMA arbiter.
// Build option DMA_RR_EN: round-robin between contending ports; default is fixed priority (port 0).
module dma_break_arb #(
  parameter int unsigned MAX_BURST = 1,
  parameter int unsigned MAX_FIELD = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_bound,
  input  logic [1:0]  req,
  input  logic [14:0] req_addr0,
  input  logic [14:0] req_addr1,
  input  logic [11:0] req_wdata0,
  input  logic [11:0] req_wdata1,
  input  logic [1:0]  req_rd,
  input  logic [11:0] mem_rdata,
  output logic        break_pend,
  output logic [1:0]  db_phase,
  output logic [14:0] dmaAddr,
  output logic [11:0] disk2mem,
  output logic        to_disk,
  output logic [1:0]  ack,
  output logic [11:0] rdata,
  output logic        fld_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DB0  = 2'b01,
    S_DB1  = 2'b10,
    S_DB2  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  burst_q, burst_d;
  logic        last_win_q, last_win_d;
  logic        win_q, win_d;
  logic [14:0] addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic [11:0] rdata_q, rdata_d;

  logic        field_over;
  logic [1:0]  masked_req;
  logic [1:0]  pick_req;
  logic        load;
  logic        both_pick;
  logic        pick;

  assign field_over = 32'(addr_q[14:12]) > MAX_FIELD;
  assign masked_req = req & (win_q ? 2'b01 : 2'b10);

`ifdef DMA_RR_EN
  assign both_pick = ~last_win_q;
`else
  // Fixed priority ignores the history bit; it is still maintained for the round-robin build.
  assign both_pick = last_win_q & 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    last_win_d = last_win_q;
    win_d      = win_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    load       = 1'b0;
    pick_req   = req;
    pick       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|req && cpu_bound) begin
          load    = 1'b1;
          state_d = S_DB0;
          burst_d = 4'd1;
        end
      end
      S_DB0: state_d = S_DB1;
      S_DB1: state_d = S_DB2;
      S_DB2: begin
        last_win_d = win_q;
        if (field_over) begin
          rdata_d = 12'd0;
        end else if (rd_q) begin
          rdata_d = mem_rdata;
        end
        // Chained break skips the CPU boundary; the port just acked cannot win again.
        if ((32'(burst_q) < MAX_BURST) && |masked_req) begin
          load     = 1'b1;
          pick_req = masked_req;
          state_d  = S_DB0;
          burst_d  = burst_q + 4'd1;
        end else begin
          state_d = S_IDLE;
          burst_d = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (&pick_req) begin
      pick = both_pick;
    end else begin
      pick = ~pick_req[0];
    end

    if (load) begin
      win_d   = pick;
      addr_d  = pick ? req_addr1 : req_addr0;
      wdata_d = pick ? req_wdata1 : req_wdata0;
      rd_d    = req_rd[pick];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      burst_q    <= 4'd0;
      last_win_q <= 1'b1;
      win_q      <= 1'b0;
      addr_q     <= 15'd0;
      wdata_q    <= 12'd0;
      rd_q       <= 1'b0;
      rdata_q    <= 12'd0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      last_win_q <= last_win_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
    end
  end

  assign break_pend = (state_q == S_IDLE) && |req;
  assign db_phase   = state_q;
  assign dmaAddr    = addr_q;
  assign disk2mem   = wdata_q;
  assign to_disk    = rd_q;
  assign rdata      = rdata_q;
  assign ack        = (state_q == S_DB2) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign fld_err    = (state_q == S_DB2) && field_over;

endmodule

// File: tb/tb_dma_break_arb.sv
// tb/tb_dma_break_arb.sv - vector table, directed break sequences and randomized model check for dma_break_arb.
module tb_dma_break_arb;
  localparam int MB = 2;
  localparam int MF = 3;
`ifdef DMA_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_bound = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [14:0] req_addr0 = 15'd0, req_addr1 = 15'd0;
  logic [11:0] req_wdata0 = 12'd0, req_wdata1 = 12'd0;
  logic [1:0]  req_rd = 2'b00;
  logic [11:0] mem_rdata = 12'd0;
  logic        break_pend, to_disk, fld_err;
  logic [1:0]  db_phase, ack;
  logic [14:0] dmaAddr;
  logic [11:0] disk2mem, rdata;

  int checks = 0;
  int errors = 0;

  dma_break_arb #(.MAX_BURST(MB), .MAX_FIELD(MF)) dut (
    .clk(clk), .reset(reset), .cpu_bound(cpu_bound), .req(req),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_rd(req_rd), .mem_rdata(mem_rdata),
    .break_pend(break_pend), .db_phase(db_phase), .dmaAddr(dmaAddr),
    .disk2mem(disk2mem), .to_disk(to_disk), .ack(ack), .rdata(rdata),
    .fld_err(fld_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       cb;
    logic [1:0] rq;
    logic [1:0] e_phase;
    logic       e_pend;
    logic [1:0] e_ack;
  } vec_t;

  vec_t vecs[41];

  function automatic vec_t mk(input logic r, input logic c, input logic [1:0] q,
                              input logic [1:0] ph, input logic pd, input logic [1:0] a);
    vec_t v;
    v.rst_n = r; v.cb = c; v.rq = q; v.e_phase = ph; v.e_pend = pd; v.e_ack = a;
    return v;
  endfunction

  task automatic run_break(input int p, input logic rd, input logic [14:0] a,
                           input logic [11:0] wd, input logic [11:0] md,
                           input logic [1:0] e_ack, input logic e_fld,
                           input logic [11:0] e_rdata, input string nm);
    int n;
    n = 0;
    if (p == 0) begin
      req_addr0 = a; req_wdata0 = wd; req_rd[0] = rd; req[0] = 1'b1;
    end else begin
      req_addr1 = a; req_wdata1 = wd; req_rd[1] = rd; req[1] = 1'b1;
    end
    cpu_bound = 1'b1;
    mem_rdata = md;
    do begin
      @(negedge clk);
      n++;
    end while (db_phase != 2'b11 && n < 8);
    check({nm, "_latency"}, n, 3);
    check({nm, "_ack"}, ack, e_ack);
    check({nm, "_fld_err"}, fld_err, e_fld);
    check({nm, "_addr"}, dmaAddr, a);
    check({nm, "_wdata"}, disk2mem, wd);
    check({nm, "_dir"}, to_disk, rd);
    req = 2'b00;
    @(negedge clk);
    check({nm, "_rdata"}, rdata, e_rdata);
    check({nm, "_idle"}, db_phase, 2'b00);
  endtask

  // Reference model state: transaction view of the break sequencer.
  int          m_phase, m_burst, m_last, m_win;
  logic [14:0] m_addr;
  logic [11:0] m_wd, m_rdata;
  logic        m_rd;

  function automatic int pick_m(input logic [1:0] r, input int last);
    if (r == 2'b11) return RR ? (1 - last) : 0;
    return r[0] ? 0 : 1;
  endfunction

  task automatic m_load(input int w);
    m_win  = w;
    m_addr = (w == 0) ? req_addr0 : req_addr1;
    m_wd   = (w == 0) ? req_wdata0 : req_wdata1;
    m_rd   = req_rd[w];
  endtask

  task automatic m_step();
    logic [1:0] rest;
    if (!reset) begin
      m_phase = 0; m_burst = 0; m_last = 1; m_win = 0;
      m_addr = 0; m_wd = 0; m_rd = 0; m_rdata = 0;
    end else if (m_phase == 0) begin
      if (req != 0 && cpu_bound) begin
        m_load(pick_m(req, m_last));
        m_phase = 1;
        m_burst = 1;
      end
    end else if (m_phase < 3) begin
      m_phase++;
    end else begin
      if (int'(m_addr[14:12]) > MF) m_rdata = 0;
      else if (m_rd) m_rdata = mem_rdata;
      m_last = m_win;
      rest = req;
      rest[m_win] = 1'b0;
      if (m_burst < MB && rest != 0) begin
        m_load(pick_m(rest, m_last));
        m_phase = 1;
        m_burst++;
      end else begin
        m_phase = 0;
        m_burst = 0;
      end
    end
  endtask

  initial begin
    logic [1:0] e_ack;
    logic e_pend, e_fld;

    repeat (2) @(negedge clk);

    // Directed vector table: ports 0/1 write with fixed addresses, burst limit 2.
    req_addr0 = 15'o10200; req_wdata0 = 12'o1234;
    req_addr1 = 15'o20400; req_wdata1 = 12'o4321;
    vecs[0] = mk(0, 0, 2'b00, 0, 0, 2'b00);
    vecs[1] = mk(1, 1, 2'b01, 0, 1, 2'b00);
    vecs[2] = mk(1, 1, 2'b01, 1, 0, 2'b00);
    vecs[3] = mk(1, 1, 2'b01, 2, 0, 2'b00);
    vecs[4] = mk(1, 1, 2'b01, 3, 0, 2'b01);
    vecs[5] = mk(1, 0, 2'b00, 0, 0, 2'b00);
    for (int i = 6; i <= 10; i++) vecs[i] = mk(1, 0, 2'b10, 0, 1, 2'b00);
    vecs[11] = mk(1, 1, 2'b10, 0, 1, 2'b00);
    vecs[12] = mk(1, 1, 2'b10, 1, 0, 2'b00);
    vecs[13] = mk(1, 1, 2'b10, 2, 0, 2'b00);
    vecs[14] = mk(1, 1, 2'b10, 3, 0, 2'b10);
    vecs[15] = mk(1, 0, 2'b11, 0, 1, 2'b00);
    for (int k = 0; k < 2; k++) begin
      vecs[16 + 7*k] = mk(1, 1, 2'b11, 0, 1, 2'b00);
      vecs[17 + 7*k] = mk(1, 1, 2'b11, 1, 0, 2'b00);
      vecs[18 + 7*k] = mk(1, 1, 2'b11, 2, 0, 2'b00);
      vecs[19 + 7*k] = mk(1, 1, 2'b11, 3, 0, 2'b01);
      vecs[20 + 7*k] = mk(1, 1, 2'b11, 1, 0, 2'b00);
      vecs[21 + 7*k] = mk(1, 1, 2'b11, 2, 0, 2'b00);
      vecs[22 + 7*k] = mk(1, 1, 2'b11, 3, 0, 2'b10);
    end
    vecs[30] = mk(1, 1, 2'b01, 0, 1, 2'b00);
    vecs[31] = mk(1, 1, 2'b01, 1, 0, 2'b00);
    vecs[32] = mk(1, 1, 2'b01, 2, 0, 2'b00);
    vecs[33] = mk(1, 1, 2'b01, 3, 0, 2'b01);
    vecs[34] = mk(1, 1, 2'b11, 0, 1, 2'b00);
    vecs[35] = mk(1, 1, 2'b11, 1, 0, 2'b00);
    vecs[36] = mk(1, 1, 2'b11, 2, 0, 2'b00);
    vecs[37] = mk(1, 1, 2'b11, 3, 0, RR ? 2'b10 : 2'b01);
    vecs[38] = mk(1, 1, 2'b11, 1, 0, 2'b00);
    vecs[39] = mk(1, 1, 2'b11, 2, 0, 2'b00);
    vecs[40] = mk(1, 1, 2'b11, 3, 0, RR ? 2'b01 : 2'b10);

    for (int i = 0; i < 41; i++) begin
      reset = vecs[i].rst_n; cpu_bound = vecs[i].cb; req = vecs[i].rq;
      #1;
      check($sformatf("vec%0d_phase", i), db_phase, vecs[i].e_phase);
      check($sformatf("vec%0d_pend", i), break_pend, vecs[i].e_pend);
      check($sformatf("vec%0d_ack", i), ack, vecs[i].e_ack);
      check($sformatf("vec%0d_fld", i), fld_err, 1'b0);
      @(negedge clk);
    end
    req = 2'b00;
    cpu_bound = 1'b0;
    @(negedge clk);

    // Hand sequences: write latch, reads, field overflow, port 1 read.
    run_break(0, 1'b0, 15'o10200, 12'o1234, 12'o7777, 2'b01, 1'b0, 12'o0000, "wr0");
    run_break(0, 1'b1, 15'o10200, 12'o0000, 12'o5252, 2'b01, 1'b0, 12'o5252, "rd0");
    run_break(0, 1'b0, 15'o30017, 12'o0707, 12'o1111, 2'b01, 1'b0, 12'o5252, "wr_hold");
    run_break(0, 1'b1, 15'o50123, 12'o0000, 12'o3333, 2'b01, 1'b1, 12'o0000, "fld5");
    run_break(1, 1'b1, 15'o21111, 12'o0000, 12'o4321, 2'b10, 1'b0, 12'o4321, "rd1");

    // Reset while in DB1 aborts without ack.
    req = 2'b01; req_rd = 2'b00; cpu_bound = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_db1", db_phase, 2'b10);
    reset = 1'b0;
    @(negedge clk);
    check("rst_phase", db_phase, 2'b00);
    check("rst_ack", ack, 2'b00);
    check("rst_pend", break_pend, 1'b1);
    check("rst_addr", dmaAddr, 15'd0);
    check("rst_rdata", rdata, 12'd0);
    reset = 1'b1; req = 2'b00; cpu_bound = 1'b0;
    #1;
    check("rst_pend_drop", break_pend, 1'b0);
    @(negedge clk);

    // Randomized run against the reference model, starting from reset.
    reset = 1'b0;
    m_step();
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      e_pend = (m_phase == 0) && (req != 0);
      e_ack  = (m_phase == 3) ? ((m_win == 0) ? 2'b01 : 2'b10) : 2'b00;
      e_fld  = (m_phase == 3) && (int'(m_addr[14:12]) > MF);
      check("rnd_phase", db_phase, m_phase);
      check("rnd_pend", break_pend, e_pend);
      check("rnd_ack", ack, e_ack);
      check("rnd_fld", fld_err, e_fld);
      check("rnd_addr", dmaAddr, m_addr);
      check("rnd_wdata", disk2mem, m_wd);
      check("rnd_dir", to_disk, m_rd);
      check("rnd_rdata", rdata, m_rdata);
      for (int p = 0; p < 2; p++) begin
        if (e_ack[p]) begin
          req[p] = 1'b0;
        end else if (!req[p] && ($urandom % 3 == 0)) begin
          if (p == 0) begin
            req_addr0 = 15'($urandom); req_wdata0 = 12'($urandom);
          end else begin
            req_addr1 = 15'($urandom); req_wdata1 = 12'($urandom);
          end
          req_rd[p] = 1'($urandom);
          req[p] = 1'b1;
        end
      end
      cpu_bound = 1'($urandom);
      mem_rdata = 12'($urandom);
      reset = ($urandom % 80) != 0;
      m_step();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
